// File: rtl/hex_scan4.sv
// Four-digit multiplexed seven-segment scanner: shadows a 16-bit value, walks the
// digits at REFRESH_DIV cycles per slot, and inserts one dark guard cycle per slot.
module hex_scan4 #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        lz_blank,
    input  logic [3:0]  dp_in,
    output logic [3:0]  num,
    output logic [3:0]  an,
    output logic        dp
);

    localparam logic [15:0] LAST = 16'(REFRESH_DIV - 1);

    logic [15:0] shadow;
    logic [15:0] pcnt;
    logic [1:0]  idx;

    logic        tc;
    logic        blk;
    logic [3:0]  nib;
    logic [3:0]  anlit;

    // Digit selection and leading-zero blanking for the current slot; digit 0 always shows.
    always_comb begin
        tc    = (pcnt == LAST);
        nib   = 4'h0;
        blk   = 1'b0;
        anlit = 4'b1111;
        case (idx)
            2'd0: begin
                nib   = shadow[3:0];
                blk   = 1'b0;
                anlit = 4'b1110;
            end
            2'd1: begin
                nib   = shadow[7:4];
                blk   = lz_blank && (shadow[15:4] == 12'h000);
                anlit = 4'b1101;
            end
            2'd2: begin
                nib   = shadow[11:8];
                blk   = lz_blank && (shadow[15:8] == 8'h00);
                anlit = 4'b1011;
            end
            default: begin
                nib   = shadow[15:12];
                blk   = lz_blank && (shadow[15:12] == 4'h0);
                anlit = 4'b0111;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= 16'h0000;
        end else if (load) begin
            shadow <= value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= 16'h0000;
            idx  <= 2'd0;
        end else if (tc) begin
            pcnt <= 16'h0000;
            idx  <= idx + 2'd1;
        end else begin
            pcnt <= pcnt + 16'h0001;
        end
    end

    // The terminal-count cycle is the guard: anodes off while the index advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num <= 4'h0;
            an  <= 4'b1111;
            dp  <= 1'b1;
        end else begin
            num <= nib;
            if (tc || blk) begin
                an <= 4'b1111;
                dp <= 1'b1;
            end else begin
                an <= anlit;
                dp <= ~dp_in[idx];
            end
        end
    end

endmodule

// File: tb/tb_hex_scan4.sv
// Self-checking bench for hex_scan4: a cycle-count reference model pushes expected
// outputs at each edge and a checker pops and compares them shortly after.
module tb_hex_scan4;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        lz_blank;
    logic [3:0]  dp_in;
    logic [3:0]  num;
    logic [3:0]  an;
    logic        dp;

    typedef struct {
        logic [3:0] num;
        logic [3:0] an;
        logic       dp;
    } exp_t;

    exp_t        q[$];
    exp_t        pushed;
    exp_t        popped;
    int          cyc;
    logic [15:0] mshadow;
    int          checks = 0;
    int          passes = 0;

    hex_scan4 #(.REFRESH_DIV(DIV)) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .value(value),
        .lz_blank(lz_blank),
        .dp_in(dp_in),
        .num(num),
        .an(an),
        .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic applyStimulus(input logic [15:0] v, input logic lz, input logic [3:0] dpi);
        @(negedge clk);
        load     = 1'b1;
        value    = v;
        lz_blank = lz;
        dp_in    = dpi;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: slot and position derived from cycles since reset release.
    always @(posedge clk) begin
        if (rst) begin
            cyc     = 0;
            mshadow = 16'h0000;
        end else begin
            int slot;
            int pos;
            logic blank;
            slot  = (cyc / DIV) % 4;
            pos   = cyc % DIV;
            blank = lz_blank && (slot >= 1) && ((mshadow >> (slot * 4)) == 16'h0000);
            pushed.num = mshadow[slot*4 +: 4];
            if (pos == DIV - 1 || blank) begin
                pushed.an = 4'b1111;
                pushed.dp = 1'b1;
            end else begin
                pushed.an = 4'b1111 & ~(4'b0001 << slot);
                pushed.dp = ~dp_in[slot];
            end
            q.push_back(pushed);
            if (load) mshadow = value;
            cyc++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            popped = q.pop_front();
            checkOutput("num", num, popped.num);
            checkOutput("an", an, popped.an);
            checkOutput("dp", {3'b000, dp}, {3'b000, popped.dp});
        end
    end

    initial begin
        bit found;
        rst      = 1'b1;
        load     = 1'b0;
        value    = 16'h0000;
        lz_blank = 1'b0;
        dp_in    = 4'b0000;
        #2;
        checkOutput("reset_an", an, 4'b1111);
        checkOutput("reset_num", num, 4'h0);
        checkOutput("reset_dp", {3'b000, dp}, 4'b0001);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("first_an", an, 4'b1110);
        checkOutput("first_num", num, 4'h0);
        runCycles(4);

        applyStimulus(16'h1A3F, 1'b0, 4'b0000);
        runCycles(32);

        applyStimulus(16'h0040, 1'b1, 4'b0000);
        runCycles(32);
        applyStimulus(16'h0000, 1'b1, 4'b0000);
        runCycles(16);

        applyStimulus(16'h1234, 1'b0, 4'b0100);
        runCycles(32);

        applyStimulus(16'h5555, 1'b0, 4'b0000);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if ((cyc / DIV) % 4 == 1 && cyc % DIV == 1) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) begin
            checks++;
            $display("[TB] FAIL wait_slot1: got timeout, expected pcnt=1 in digit 1");
        end
        load  = 1'b1;
        value = 16'h6666;
        @(negedge clk);
        load  = 1'b0;
        runCycles(16);

        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if ((cyc / DIV) % 4 == 2 && cyc % DIV == 1) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) begin
            checks++;
            $display("[TB] FAIL wait_slot2: got timeout, expected digit 2");
        end
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_an", an, 4'b1111);
        checkOutput("async_num", num, 4'h0);
        checkOutput("async_dp", {3'b000, dp}, 4'b0001);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        runCycles(20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
